seq_divmod: RTL
===============

// Module: seq_divmod
// PURPOSE
//  Iterative, multi-cycle unsigned divider returning quotient and remainder.
//  Sequential counterpart to the single-cycle combinational remainder datapath component.
//  Used where a full-width combinational divide misses timing.
//  Sits in the datapath behind a start/valid/ready handshake driven by the schedule controller.
// PARAMETERS
//  DATAWIDTH  8  operand/result width in bits; legal values 2..64
// PORTS
//  Clk        input   1          single clock; all state updates on rising edge
//  Rst        input   1          synchronous, active-high reset
//  start      input   1          request; accepted only in IDLE
//  a          input   DATAWIDTH  dividend, sampled on accepted start
//  b          input   DATAWIDTH  divisor, sampled on accepted start
//  busy       output  1          high in BUSY and DONE (not accepting start)
//  out_valid  output  1          high in DONE; quot/rem valid
//  out_ready  input   1          consumer accepts result while out_valid=1
//  quot       output  DATAWIDTH  a / b (unsigned)
//  rem        output  DATAWIDTH  a % b (unsigned)
//  div0       output  1          only with SEQ_DIVMOD_DIV0_EN; b was zero
// BEHAVIOUR
//  Reset (Rst=1 at edge): state=IDLE, iteration count=0.
//   Reset values: busy=0, out_valid=0, quot=0, rem=0, div0=0.
//   Reset overrides all activity, including mid-BUSY and DONE; the operation in flight is discarded.
//  FSM IDLE -> BUSY -> DONE -> IDLE.
//   IDLE: start=1 latches a and b, clears the partial remainder, sets count=0, goes to BUSY.
//   BUSY: runs one restoring step per cycle, MSB first.
//    pr' = {pr, dividend_msb}; if pr' >= b then pr' -= b and the quotient bit is 1.
//    After DATAWIDTH steps, goes to DONE.
//   DONE: out_valid=1 and quot/rem are stable.
//    On out_ready=1, goes to IDLE. quot/rem hold their values until the next accepted start.
//  Latency: start accepted at edge N gives out_valid=1 after edge N+DATAWIDTH.
//   DATAWIDTH=8: 8 BUSY cycles, then DONE.
//  Throughput: with out_ready held high and start held high, one result every DATAWIDTH+2 cycles.
//   DONE->IDLE takes one edge; start is re-sampled in IDLE.
//  start is ignored in BUSY and DONE; operand changes there have no effect.
//  Partial remainder is DATAWIDTH+1 bits wide so the compare never overflows.
//   rem output = low DATAWIDTH bits.
//  b=0 without the macro: the normal iterations run.
//   Result is quot={DATAWIDTH{1'b1}}, rem=a, same latency.
// CONFIGURATION
//  SEQ_DIVMOD_DIV0_EN defined:
//   Adds the div0 output.
//   If b==0 at accept: go IDLE->DONE directly (out_valid after 1 edge), quot=all ones, rem=a, div0=1.
//   div0 clears on the next accepted start or on reset.
//  Not defined: no div0 port; b==0 takes the full-latency path described above.
// STRUCTURE
//  Package seq_divmod_pkg:
//   state encoding IDLE=2'd0, BUSY=2'd1, DONE=2'd2.
//   function for count width, $clog2(DATAWIDTH+1).
//  Sub-module divmod_step (combinational, parameterised DATAWIDTH):
//   inputs: partial remainder, next dividend bit, divisor.
//   outputs: next partial remainder, quotient bit.
//  Top level holds the FSM, counter, shift registers and output registers.
// TESTING (DATAWIDTH=8)
//  1. a=100, b=7, start one cycle: out_valid after 8 BUSY cycles; quot=14, rem=2; busy=1 from the edge after start to DONE exit.
//  2. a=5, b=9 -> quot=0, rem=5. Then a=255, b=1 -> quot=255, rem=0. Use out_ready=1 and start held high; results are spaced 10 cycles apart.
//  3. a=77, b=0:
//   without macro -> quot=255, rem=77 at full latency;
//   with SEQ_DIVMOD_DIV0_EN -> out_valid after 1 edge, div0=1, quot=255, rem=77.
//  4. Rst=1 at the 4th BUSY cycle of a=200, b=3 -> next cycle busy=0, out_valid=0, quot=rem=0; a fresh start then gives 66/2 correctly.
//  5. Backpressure: in DONE hold out_ready=0 for 5 cycles with start=1 and new operands; out_valid stays 1, quot/rem are unchanged, start is ignored.
//  6. Random sweep: 1000 random a and b (b!=0) vs reference a/b and a%b. Check the latency of each result.

Source files
------------

// File: rtl/seq_divmod_pkg.sv
// ---------------------------------------------------------------------------
// seq_divmod_pkg
//   Shared definitions for the iterative unsigned divider seq_divmod:
//   FSM state encoding and the iteration-counter width helper.
// ---------------------------------------------------------------------------
package seq_divmod_pkg;

   // FSM state encoding
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   // Counter width able to hold 0..w
   function automatic int unsigned cnt_width(input int unsigned w);
      return $clog2(w + 1);
   endfunction

endpackage : seq_divmod_pkg

// File: rtl/seq_divmod_step.sv
// ---------------------------------------------------------------------------
// divmod_step
//   One combinational restoring-division step, MSB first.
//   Ports:
//     pr       in   DATAWIDTH  current partial remainder (always < divisor)
//     din      in   1          next dividend bit shifted in
//     divisor  in   DATAWIDTH  divisor
//     pr_next  out  DATAWIDTH  partial remainder after this step
//     q_bit    out  1          quotient bit produced by this step
// ---------------------------------------------------------------------------
module divmod_step #(
   parameter int unsigned DATAWIDTH = 8
) (
   input  logic [DATAWIDTH-1:0] pr,
   input  logic                 din,
   input  logic [DATAWIDTH-1:0] divisor,
   output logic [DATAWIDTH-1:0] pr_next,
   output logic                 q_bit
);

   // Shifted remainder is one bit wider so the compare cannot overflow.
   logic [DATAWIDTH:0] shifted;

   assign shifted = {pr, din};
   assign q_bit   = (shifted >= {1'b0, divisor});

   // The result is always below the divisor (or equals the shifted dividend
   // prefix when the divisor is zero), so it fits in DATAWIDTH bits.
   assign pr_next = q_bit ? DATAWIDTH'(shifted - {1'b0, divisor})
                          : DATAWIDTH'(shifted);

endmodule : divmod_step

// File: rtl/seq_divmod.sv
// ---------------------------------------------------------------------------
// seq_divmod
//   Iterative unsigned divider: one restoring step per cycle, producing
//   quotient and remainder after DATAWIDTH BUSY cycles, with a
//   start/busy and out_valid/out_ready handshake.
//   Optional macro SEQ_DIVMOD_DIV0_EN adds the div0 output and a one-edge
//   shortcut for a zero divisor.
//   Ports:
//     Clk        in   1          clock, rising edge
//     Rst        in   1          synchronous active-high reset
//     start      in   1          request, accepted only in IDLE
//     a          in   DATAWIDTH  dividend, sampled on accepted start
//     b          in   DATAWIDTH  divisor, sampled on accepted start
//     busy       out  1          high in BUSY and DONE
//     out_valid  out  1          high in DONE, quot/rem valid
//     out_ready  in   1          consumer takes the result
//     quot       out  DATAWIDTH  a / b
//     rem        out  DATAWIDTH  a % b
//     div0       out  1          (SEQ_DIVMOD_DIV0_EN only) divisor was zero
// ---------------------------------------------------------------------------
module seq_divmod
   import seq_divmod_pkg::*;
#(
   parameter int unsigned DATAWIDTH = 8
) (
   input  logic                 Clk,
   input  logic                 Rst,
   input  logic                 start,
   input  logic [DATAWIDTH-1:0] a,
   input  logic [DATAWIDTH-1:0] b,
   output logic                 busy,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [DATAWIDTH-1:0] quot,
   output logic [DATAWIDTH-1:0] rem
`ifdef SEQ_DIVMOD_DIV0_EN
   ,
   output logic                 div0
`endif
);

   localparam int unsigned CW = cnt_width(DATAWIDTH);

   logic [1:0]           state, state_next;
   logic [CW-1:0]        count;
   logic [DATAWIDTH-1:0] shreg;     // dividend out at MSB, quotient in at LSB
   logic [DATAWIDTH-1:0] divisor;
   logic [DATAWIDTH-1:0] pr;
   logic [DATAWIDTH-1:0] pr_step;
   logic                 q_bit;
   logic                 accept_c;
   logic                 last_step_c;
`ifdef SEQ_DIVMOD_DIV0_EN
   logic                 zero_div_c;
`endif

   divmod_step #(
      .DATAWIDTH (DATAWIDTH)
   ) u_step (
      .pr      (pr),
      .din     (shreg[DATAWIDTH-1]),
      .divisor (divisor),
      .pr_next (pr_step),
      .q_bit   (q_bit)
   );

   // State register
   always_ff @(posedge Clk) begin
      if (Rst) state <= ST_IDLE;
      else     state <= state_next;
   end

   // Next-state and step control
   always_comb begin
      state_next  = state;
      accept_c    = 1'b0;
      last_step_c = 1'b0;
`ifdef SEQ_DIVMOD_DIV0_EN
      zero_div_c  = 1'b0;
`endif
      case (state)
         ST_IDLE: begin
            if (start) begin
               accept_c   = 1'b1;
`ifdef SEQ_DIVMOD_DIV0_EN
               zero_div_c = (b == '0);
               state_next = zero_div_c ? ST_DONE : ST_BUSY;
`else
               state_next = ST_BUSY;
`endif
            end
         end
         ST_BUSY: begin
            if (count == CW'(DATAWIDTH - 1)) begin
               last_step_c = 1'b1;
               state_next  = ST_DONE;
            end
         end
         ST_DONE: begin
            if (out_ready) state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Datapath and registered outputs
   always_ff @(posedge Clk) begin
      if (Rst) begin
         count     <= '0;
         shreg     <= '0;
         divisor   <= '0;
         pr        <= '0;
         busy      <= 1'b0;
         out_valid <= 1'b0;
         quot      <= '0;
         rem       <= '0;
`ifdef SEQ_DIVMOD_DIV0_EN
         div0      <= 1'b0;
`endif
      end else begin
         busy      <= (state_next != ST_IDLE);
         out_valid <= (state_next == ST_DONE);
         if (accept_c) begin
            shreg   <= a;
            divisor <= b;
            pr      <= '0;
            count   <= '0;
`ifdef SEQ_DIVMOD_DIV0_EN
            div0    <= zero_div_c;
            if (zero_div_c) begin
               quot <= '1;
               rem  <= a;
            end
`endif
         end else if (state == ST_BUSY) begin
            shreg <= {shreg[DATAWIDTH-2:0], q_bit};
            pr    <= pr_step;
            count <= count + CW'(1);
            if (last_step_c) begin
               quot <= {shreg[DATAWIDTH-2:0], q_bit};
               rem  <= pr_step;
            end
         end
      end
   end

endmodule : seq_divmod
